// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// register-index constants, mul/div counter width and the load-use helper.
package pipe_pkg;

    localparam int RIDX_W = 5;
    localparam logic [RIDX_W-1:0] REG_ZERO = 5'd0;

    // Width of the mul/div residence down-counter.
    localparam int MD_CNT_W = 3;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    // Per-stage control bundle driven onto the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_clr;
        logic id_ex_clr;
        logic ex_mem_clr;
        logic mem_wb_clr;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FLOW = '{
        pc_en:      1'b1,
        if_id_en:   1'b1,
        id_ex_en:   1'b1,
        ex_mem_en:  1'b1,
        mem_wb_en:  1'b1,
        if_id_clr:  1'b0,
        id_ex_clr:  1'b0,
        ex_mem_clr: 1'b0,
        mem_wb_clr: 1'b0
    };

    // A load in EX feeding a source of the instruction in ID.
    // x0 is hard-wired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic              is_load,
        input logic [RIDX_W-1:0] rd,
        input logic [RIDX_W-1:0] rs1,
        input logic [RIDX_W-1:0] rs2
    );
        return is_load && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/md_timer.sv
// Down-counter tracking remaining EX residence of a mul/div op.
// Ports: clk, rst (async high), load/load_val, dec (saturates at 0), cnt, zero.
module md_timer
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic [MD_CNT_W-1:0] cnt,
    output logic                zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB stage registers.
// Inputs: clk, rst (async high), ID sources, EX dest/load/mul-div/branch,
//   MEM req/ack. Outputs: per-stage en/clr, pc_en, md_busy, md_done.
// Build option PIPE_CTRL_PERF_EN adds perf_stall_cnt / perf_flush_cnt.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic [RIDX_W-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_md_start,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_clr,
    output logic              id_ex_clr,
    output logic              ex_mem_clr,
    output logic              mem_wb_clr,
    output logic              md_busy,
    output logic              md_done
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
`endif
);

    // The counter is 3 bits and is loaded with MD_CYCLES-2.
    if (MD_CYCLES < 1 || MD_CYCLES > 9 || CNT_WIDTH < 1) begin : g_param_chk
        $error("pipe_hazard_ctrl: MD_CYCLES must be 1..9, CNT_WIDTH >= 1");
    end

    localparam logic MD_MULTI = (MD_CYCLES > 1);
    localparam logic [MD_CNT_W-1:0] MD_LOAD =
        (MD_CYCLES > 1) ? MD_CNT_W'(MD_CYCLES - 2) : '0;

    md_state_e           state;
    logic [MD_CNT_W-1:0] cnt;
    logic                cnt_zero;
    logic                mem_stall;
    logic                load_use;
    logic                md_go;
    logic                md_hold;
    logic                md_fin;
    logic                tmr_load;
    stage_ctrl_t         ctrl;

    assign mem_stall = mem_req & ~mem_ack;
    assign load_use  = load_use_hit(ex_is_load, ex_rd, id_rs1, id_rs2);

    // A start in the completing cycle is not a new op: md_go needs ST_RUN.
    assign md_go   = (state == ST_RUN) & ex_md_start & MD_MULTI;
    assign md_hold = (state == ST_MD_BUSY) & ~cnt_zero;
    assign md_fin  = (state == ST_MD_BUSY) & cnt_zero & ~mem_stall;

    assign md_busy = (state == ST_MD_BUSY);
    assign md_done = md_fin;

    assign tmr_load = md_go & ~mem_stall;

    // Counter keeps running through memory stalls and parks at zero.
    md_timer u_md_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (MD_LOAD),
        .dec      (~tmr_load),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        ctrl = CTRL_FLOW;
        if (mem_stall) begin
            // Drain MEM into WB as a bubble, everything upstream holds.
            ctrl.pc_en      = 1'b0;
            ctrl.if_id_en   = 1'b0;
            ctrl.id_ex_en   = 1'b0;
            ctrl.ex_mem_en  = 1'b0;
            ctrl.mem_wb_clr = 1'b1;
        end else if (md_go || md_hold) begin
            // EX keeps the op; a bubble flows on into MEM.
            ctrl.pc_en      = 1'b0;
            ctrl.if_id_en   = 1'b0;
            ctrl.id_ex_en   = 1'b0;
            ctrl.ex_mem_clr = 1'b1;
        end else if (ex_br_taken) begin
            ctrl.if_id_clr = 1'b1;
            ctrl.id_ex_clr = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en     = 1'b0;
            ctrl.if_id_en  = 1'b0;
            ctrl.id_ex_clr = 1'b1;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign if_id_en   = ctrl.if_id_en;
    assign id_ex_en   = ctrl.id_ex_en;
    assign ex_mem_en  = ctrl.ex_mem_en;
    assign mem_wb_en  = ctrl.mem_wb_en;
    assign if_id_clr  = ctrl.if_id_clr;
    assign id_ex_clr  = ctrl.id_ex_clr;
    assign ex_mem_clr = ctrl.ex_mem_clr;
    assign mem_wb_clr = ctrl.mem_wb_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (!mem_stall) begin
            if (md_go) begin
                state <= ST_MD_BUSY;
            end else if (md_fin) begin
                state <= ST_RUN;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_en && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (ctrl.if_id_clr && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
